// File: rtl/request_dispatcher.sv
// rtl/request_dispatcher.sv - request capture and grant sequencing in front of the 8-input priority encoder
module request_dispatcher (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [0:7] req,
  output logic       enc_en,
  output logic [0:7] enc_I,
  input  logic [0:2] enc_Y,
  input  logic       enc_done,
  output logic       out_valid,
  output logic [0:2] out_code,
  input  logic       out_ready,
  output logic [0:7] pending,
  output logic       overflow,
  input  logic       clr_ovf
);

  typedef enum logic [1:0] {IDLE, ENCODE, OFFER} state_t;

  state_t     state;
  logic       accept;
  logic [2:0] code_idx;
  logic [0:7] clear_mask;
  logic [0:7] pending_next;
  logic       ovf_set;

  assign enc_I    = pending;
  assign accept   = out_valid & out_ready;
  // out_code bit 0 carries weight 1, so reverse it into a natural binary index
  assign code_idx = {out_code[2], out_code[1], out_code[0]};

  always_comb begin
    clear_mask = '0;
    if (accept) clear_mask[code_idx] = 1'b1;
  end

  // A new strobe on a bit being granted this cycle re-arms it without counting as overflow
  assign pending_next = (pending & ~clear_mask) | req;
  assign ovf_set      = |(req & pending & ~clear_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      pending  <= pending_next;
      overflow <= ovf_set | (overflow & ~clr_ovf);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      enc_en    <= 1'b0;
      out_valid <= 1'b0;
      out_code  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pending != '0) begin
            state  <= ENCODE;
            enc_en <= 1'b1;
          end
        end
        ENCODE: begin
          enc_en <= 1'b0;
          if (enc_done) begin
            out_code  <= enc_Y;
            out_valid <= 1'b1;
            state     <= OFFER;
          end else begin
            state <= IDLE;
          end
        end
        OFFER: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          enc_en    <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
